// File: rtl/sequenciador_programa_pkg.sv
// seq_pkg: opcodes, halt sentinel and FSM state encoding shared by the program sequencer.
package seq_pkg;
  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [15:0] HALT_WORD = 16'hFFFF;
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_IMM    = 3'd2,
    S_WAIT   = 3'd3,
    S_HALTED = 3'd4
  } state_t;
  function automatic logic is_two_word(input logic [2:0] op);
    case (op)
      OP_MVI:                return 1'b1;
      OP_MV, OP_ADD, OP_SUB: return 1'b0;
      default:               return 1'b0;
    endcase
  endfunction
endpackage

// File: rtl/sequenciador_programa_memoria.sv
// memoria_programa: DEPTH x 16 program store, synchronous write, asynchronous read.
module memoria_programa #(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [15:0]   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [15:0]   rdata_o
);
  logic [15:0] mem_q [DEPTH];
  always_ff @(posedge clk_i)
    if (we_i) mem_q[waddr_i] <= wdata_i;
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/sequenciador_programa.sv
// sequenciador_programa: feeds program words and Run pulses to the multicycle CPU, waiting on Done.
// Optional Done watchdog enabled by defining SEQ_WATCHDOG_EN.
module sequenciador_programa
  import seq_pkg::*;
#(
  parameter int DEPTH   = 32,
  parameter int AW      = 5,
  parameter int TIMEOUT = 15
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          Start,
  input  logic          Wr_en,
  input  logic [AW-1:0] Wr_addr,
  input  logic [15:0]   Wr_data,
  input  logic          Done,
  output logic [15:0]   DIN,
  output logic          Run,
  output logic [AW-1:0] PC,
  output logic          Halted,
  output logic          Error
);
  if (DEPTH != (1 << AW) || TIMEOUT < 1) begin : g_bad_cfg
    $error("sequenciador_programa: DEPTH must equal 2**AW and TIMEOUT must be positive");
  end
  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [15:0]   din_q, din_d;
  logic          err_q, err_d;
  logic [15:0]   rdata;
  logic          is_halt;
  logic          wd_expired;
  memoria_programa #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk_i   (Clock),
    .we_i    (Wr_en && (state_q == S_IDLE || state_q == S_HALTED)),
    .waddr_i (Wr_addr),
    .wdata_i (Wr_data),
    .raddr_i (pc_q),
    .rdata_o (rdata)
  );
`ifdef SEQ_WATCHDOG_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wd_q;
  always_ff @(posedge Clock)
    wd_q <= (Reset || state_q != S_WAIT) ? '0 : wd_q + CW'(1);
  assign wd_expired = wd_q == CW'(TIMEOUT - 1);
`else
  assign wd_expired = 1'b0;
`endif
  assign is_halt = rdata == HALT_WORD;
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    din_d   = din_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE:   state_d = Start ? S_FETCH : S_IDLE;
      S_FETCH:
        if (is_halt) state_d = S_HALTED;
        else begin
          pc_d    = pc_q + AW'(1);
          din_d   = rdata;
          state_d = is_two_word(rdata[8:6]) ? S_IMM : S_WAIT;
        end
      S_IMM: begin
        pc_d    = pc_q + AW'(1);
        din_d   = rdata;
        state_d = S_WAIT;
      end
      S_WAIT:
        if (Done) state_d = S_FETCH;
        else if (wd_expired) begin
          state_d = S_HALTED;
          err_d   = 1'b1;
        end
      S_HALTED:
        if (Start) begin
          pc_d    = '0;
          err_d   = 1'b0;
          state_d = S_FETCH;
        end
      default:  state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge Clock)
    if (Reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      din_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      din_q   <= din_d;
      err_q   <= err_d;
    end
  // The word being issued is shown live; otherwise the last issued word is held.
  assign Run    = state_q == S_FETCH && !is_halt;
  assign DIN    = (Run || state_q == S_IMM) ? rdata : din_q;
  assign PC     = pc_q;
  assign Halted = state_q == S_HALTED;
  assign Error  = err_q;
endmodule
